register_tree_replace_ctrl: RTL and testbench

//   Initiator for register_tree's replace interface (replace/new_item/top_item).

---
 rtl/register_tree_replace_ctrl.sv | 156 +++++++++++++++
 tb/tb_register_tree_replace_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_tree_replace_ctrl.sv
// register_tree_replace_ctrl
//   Drives the replace interface of a register_tree. New items come in on a
//   valid/ready stream. Each accepted item produces one single-cycle replace
//   pulse. The controller then waits for the tree to re-sort, and hands the
//   displaced top item out on a second valid/ready stream.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_ni           asynchronous, active-low reset
//   in_valid_i       producer offers in_item_i
//   in_ready_o       controller can accept (high only while idle)
//   in_item_i        item to insert into the tree
//   out_valid_o      displaced item is available on out_item_o
//   out_ready_i      consumer accepts out_item_o
//   out_item_o       item that was at the tree top when the insert was accepted
//   tree_replace_o   one-cycle replace pulse to register_tree
//   tree_new_item_o  item presented to register_tree.new_item
//   tree_top_item_i  register_tree.top_item
//   busy_o           controller is not idle
//   ops_done_o       completed output handshakes, wraps modulo 2^CNT_WIDTH

module register_tree_replace_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int INIT_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_item_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_item_o,
  output logic                  tree_replace_o,
  output logic [DATA_WIDTH-1:0] tree_new_item_o,
  input  logic [DATA_WIDTH-1:0] tree_top_item_i,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  ops_done_o
);

  // One shared down-counter serves both the post-reset wait and the
  // re-sort wait. It only ever holds a load value minus some steps, so it
  // needs enough bits for the larger of the two load values.
  localparam int MaxWait = (INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES;
  localparam int WaitW   = (MaxWait > 1) ? $clog2(MaxWait) : 1;

  localparam logic [WaitW-1:0] InitLoad   = WaitW'(INIT_CYCLES - 1);
  localparam logic [WaitW-1:0] SettleLoad = WaitW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    SETTLE,
    EMIT
  } state_e;

  state_e                state_q, state_d;
  logic [WaitW-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_item_q, out_item_d;
  logic [DATA_WIDTH-1:0] new_item_q, new_item_d;
  logic [CNT_WIDTH-1:0]  ops_q, ops_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      cnt_q      <= InitLoad;
      out_item_q <= '0;
      new_item_q <= '0;
      ops_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_item_q <= out_item_d;
      new_item_q <= new_item_d;
      ops_q      <= ops_d;
    end
  end

  // The top item is captured at the accept edge. At that edge the tree has
  // finished settling from the previous replace. Nothing samples
  // tree_top_item_i again until the next accept, so values the tree presents
  // during the re-sort window cannot leak out.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_item_d = out_item_q;
    new_item_d = new_item_q;
    ops_d      = ops_q;

    unique case (state_q)
      INIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - WaitW'(1);
        end
      end
      IDLE: begin
        if (in_valid_i) begin
          new_item_d = in_item_i;
          out_item_d = tree_top_item_i;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = SettleLoad;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q - WaitW'(1);
        end
      end
      EMIT: begin
        if (out_ready_i) begin
          ops_d   = ops_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = InitLoad;
      end
    endcase
  end

  // All handshake and pulse outputs decode only the registered state. Because
  // of this, no input feeds through combinationally to an output, and the
  // reset values appear as soon as rst_ni falls.
  always_comb begin
    in_ready_o      = 1'b0;
    out_valid_o     = 1'b0;
    tree_replace_o  = 1'b0;
    busy_o          = 1'b1;
    out_item_o      = out_item_q;
    tree_new_item_o = new_item_q;
    ops_done_o      = ops_q;

    if (state_q == IDLE) begin
      in_ready_o = 1'b1;
      busy_o     = 1'b0;
    end
    if (state_q == ISSUE) begin
      tree_replace_o = 1'b1;
    end
    if (state_q == EMIT) begin
      out_valid_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_register_tree_replace_ctrl.sv
// Testbench for register_tree_replace_ctrl.
// The bench models a four-entry register_tree as a plain array. The tree
// top is the array maximum. While the tree is re-sorting, the modelled top
// shows junk values. The controller's expected outputs come from a
// timeline view:
//   - how many edges since reset release,
//   - how many edges since the current item was accepted.
// A negedge process compares every output against that view. The directed
// tests also pin literal values taken from a hand trace.

module tb_register_tree_replace_ctrl;

  localparam int DW     = 32;
  localparam int INIT   = 4;
  localparam int SETTLE = 4;
  localparam int CW     = 2;

  logic          clk;
  logic          rstN;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inItem;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outItem;
  logic          treeReplace;
  logic [DW-1:0] treeNewItem;
  logic [DW-1:0] treeTop;
  logic          busy;
  logic [CW-1:0] opsDone;

  int vectors     = 0;
  int miscompares = 0;

  register_tree_replace_ctrl #(
    .DATA_WIDTH   (DW),
    .INIT_CYCLES  (INIT),
    .SETTLE_CYCLES(SETTLE),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .in_valid_i     (inValid),
    .in_ready_o     (inReady),
    .in_item_i      (inItem),
    .out_valid_o    (outValid),
    .out_ready_i    (outReady),
    .out_item_o     (outItem),
    .tree_replace_o (treeReplace),
    .tree_new_item_o(treeNewItem),
    .tree_top_item_i(treeTop),
    .busy_o         (busy),
    .ops_done_o     (opsDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: a register_tree of depth 4, plus the expected controller
  // behaviour.
  logic [DW-1:0] tree [4];
  logic [DW-1:0] treeMax;
  int            maxPos;
  int            settleCnt;

  int            initLeft;
  logic          opActive;
  int            age;
  int            mOps;
  logic [DW-1:0] mOut;
  logic [DW-1:0] mNew;

  int accCnt;
  int hsCnt;

  always_comb begin
    treeMax = tree[0];
    maxPos  = 0;
    for (int i = 1; i < 4; i++) begin
      if (tree[i] > treeMax) begin
        treeMax = tree[i];
        maxPos  = i;
      end
    end
    treeTop = (settleCnt == 0) ? treeMax : (32'hBAD0_0000 | settleCnt);
  end

  // Timeline of one operation:
  //   - age 0 is the cycle after the accept edge, when the pulse is out;
  //   - the output becomes valid once 1+SETTLE edges have passed since the
  //     accept;
  //   - the operation ends on the output handshake.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tree      <= '{32'd10, 32'd80, 32'd140, 32'd150};
      settleCnt <= 0;
      initLeft  <= INIT;
      opActive  <= 1'b0;
      age       <= 0;
      mOps      <= 0;
      mOut      <= '0;
      mNew      <= '0;
      accCnt    <= 0;
      hsCnt     <= 0;
    end else begin
      if (initLeft > 0) begin
        initLeft <= initLeft - 1;
      end else if (!opActive) begin
        if (inValid) begin
          opActive <= 1'b1;
          age      <= 0;
          mOut     <= treeTop;
          mNew     <= inItem;
        end
      end else if (age >= 1 + SETTLE) begin
        if (outReady) begin
          opActive <= 1'b0;
          mOps     <= mOps + 1;
        end
      end else begin
        age <= age + 1;
      end

      if (treeReplace) begin
        tree[maxPos] <= treeNewItem;
        settleCnt    <= SETTLE;
      end else if (settleCnt > 0) begin
        settleCnt <= settleCnt - 1;
      end

      if (inValid && inReady) accCnt <= accCnt + 1;
      if (outValid && outReady) hsCnt <= hsCnt + 1;
    end
  end

  logic expInReady;
  logic expOutValid;
  logic expReplace;

  always_comb begin
    expInReady  = !opActive && (initLeft == 0);
    expOutValid = opActive && (age >= 1 + SETTLE);
    expReplace  = opActive && (age == 0);
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] item, input logic rdy);
    inValid  = v;
    inItem   = item;
    outReady = rdy;
  endtask

  always @(negedge clk) begin
    checkOutput("sbInReady", DW'(inReady), DW'(expInReady));
    checkOutput("sbOutValid", DW'(outValid), DW'(expOutValid));
    checkOutput("sbReplace", DW'(treeReplace), DW'(expReplace));
    checkOutput("sbBusy", DW'(busy), DW'(!expInReady));
    checkOutput("sbOutItem", outItem, mOut);
    checkOutput("sbNewItem", treeNewItem, mNew);
    checkOutput("sbOpsDone", DW'(opsDone), DW'(mOps % (1 << CW)));
  end

  task automatic doReset(output int readyAfter);
    @(posedge clk); #1;
    rstN = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    readyAfter = 0;
    while (!inReady && readyAfter < 50) begin
      @(posedge clk); #1;
      readyAfter++;
    end
  endtask

  task automatic pushItem(input logic [DW-1:0] item, output logic [DW-1:0] got, output int lat,
                          output logic repl, output logic [DW-1:0] newItem);
    int n;
    applyStimulus(1'b1, item, 1'b0);
    n = 0;
    while (!inReady && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("acceptWait", DW'(n < 100), 32'd1);
    @(posedge clk); #1;
    repl    = treeReplace;
    newItem = treeNewItem;
    applyStimulus(1'b0, 32'hA5A5_A5A5, 1'b0);
    lat = 0;
    while (!outValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("emitWait", DW'(lat < 100), 32'd1);
    got = outItem;
    applyStimulus(1'b0, '0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int            n;
    int            lat;
    logic          repl;
    logic          sawValid;
    logic [DW-1:0] got;
    logic [DW-1:0] ni;

    rstN = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);

    // T1: after reset release, the input stream opens after INIT cycles.
    doReset(n);
    checkOutput("t1InitWait", DW'(n), 32'd4);

    // T2: the first push displaces the top item, 150.
    pushItem(32'd5, got, lat, repl, ni);
    checkOutput("t2Replace", DW'(repl), 32'd1);
    checkOutput("t2NewItem", ni, 32'd5);
    checkOutput("t2Latency", DW'(lat), 32'd5);
    checkOutput("t2Out150", got, 32'd150);
    pushItem(32'd7, got, lat, repl, ni);
    checkOutput("t2Out140", got, 32'd140);

    // T3: backpressure holds the output. Inputs offered meanwhile are
    // ignored.
    doReset(n);
    applyStimulus(1'b1, 32'd5, 1'b0);
    while (!inReady) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'd99, 1'b0);
    n = 0;
    while (!outValid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3HoldValid", DW'(outValid), 32'd1);
      checkOutput("t3HoldItem", outItem, 32'd150);
      checkOutput("t3NoReady", DW'(inReady), 32'd0);
      checkOutput("t3NoReplace", DW'(treeReplace), 32'd0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, '0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t3OpsDone", DW'(opsDone), 32'd1);
    checkOutput("t3ReadyBack", DW'(inReady), 32'd1);

    // T4: a sequence of pushes, each displacing the current maximum.
    doReset(n);
    pushItem(32'd200, got, lat, repl, ni);
    checkOutput("t4Out150", got, 32'd150);
    pushItem(32'd1, got, lat, repl, ni);
    checkOutput("t4Out200", got, 32'd200);
    pushItem(32'd3, got, lat, repl, ni);
    checkOutput("t4Out140", got, 32'd140);

    // T5: reset while the tree is re-sorting.
    applyStimulus(1'b1, 32'd9, 1'b0);
    while (!inReady) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("t5InReady", DW'(inReady), 32'd0);
    checkOutput("t5OutValid", DW'(outValid), 32'd0);
    checkOutput("t5Replace", DW'(treeReplace), 32'd0);
    checkOutput("t5OpsDone", DW'(opsDone), 32'd0);
    checkOutput("t5Busy", DW'(busy), 32'd1);
    checkOutput("t5OutItem", outItem, 32'd0);
    checkOutput("t5NewItem", treeNewItem, 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    n = 0;
    while (!inReady && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("t5InitWait", DW'(n), 32'd4);
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sawValid |= outValid | treeReplace;
      @(posedge clk); #1;
    end
    checkOutput("t5NoStale", DW'(sawValid), 32'd0);
    applyStimulus(1'b0, '0, 1'b0);

    // T6: five operations wrap the 2-bit counter. Random toggling follows.
    doReset(n);
    for (int i = 0; i < 5; i++) begin
      pushItem(DW'(20 + i), got, lat, repl, ni);
    end
    checkOutput("t6Wrap", DW'(opsDone), 32'd1);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'($urandom_range(0, 1)), DW'($urandom_range(0, 1000)), 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t6Conserve", DW'(accCnt - hsCnt), 32'd0);
    checkOutput("t6OpsMod", DW'(opsDone), DW'(hsCnt % 4));
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
